// File: rtl/dotprod_pkg.sv
// Shared definitions for the dotprod vector loader: default widths, FSM state
// encoding and result error-flag bit positions.
package dotprod_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_KICK   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // Bit positions within res_err.
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVF     = 1;

endpackage

// File: rtl/dotprod_vec_loader_if.sv
// Element-pair input stream and result return channel of the vector loader.
// The loader is the slave; the producer/consumer side is the master.
interface dotprod_vec_loader_if
  import dotprod_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_W-1:0]     res_data;
  logic [DEPTH_LOG2:0]   res_len;
  logic [1:0]            res_err;

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
    input  in_ready, res_valid, res_data, res_len, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready,
    output in_ready, res_valid, res_data, res_len, res_err
  );

endinterface

// File: rtl/dotprod_vec_ram.sv
// Single-port vector RAM: one read-or-write access per cycle, synchronous read
// with one cycle of latency. The read register holds while no read is issued.
module dotprod_vec_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk_i,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rd_q;

  // Write or read the addressed word when the port is enabled.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wd_i;
      end else begin
        rd_q <= mem_q[addr_i];
      end
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/dotprod_vec_loader.sv
// Feeder for the dotprod kernel: buffers an (a,b) pair stream into two vector
// RAMs, kicks the kernel, serves its RAM ports and returns its result.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_LOAD   | accepting pairs into RAM a/b at cnt
//  ST_KICK   | one-cycle k_start pulse, k_n valid from here
//  ST_RUN    | kernel owns the RAM ports, watchdog counting down
//  ST_RESULT | result held on res_* until the consumer takes it
module dotprod_vec_loader
  import dotprod_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int TIMEOUT    = 65535
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  dotprod_vec_loader_if.slave    io,
  output logic                   k_start,
  input  logic                   k_done,
  output logic [31:0]            k_n,
  input  logic [DATA_W-1:0]      k_return_val,
  input  logic [ADDR_W-1:0]      k_a_address0,
  input  logic                   k_a_ce0,
  input  logic                   k_a_we0,
  input  logic [DATA_W-1:0]      k_a_ad0,
  output logic [DATA_W-1:0]      k_a_q0,
  input  logic [ADDR_W-1:0]      k_b_address0,
  input  logic                   k_b_ce0,
  input  logic                   k_b_we0,
  input  logic [DATA_W-1:0]      k_b_ad0,
  output logic [DATA_W-1:0]      k_b_q0
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e                 state_q;
  logic [DEPTH_LOG2-1:0]  cnt_q;
  logic                   in_ready_q;
  logic                   k_start_q;
  logic [31:0]            k_n_q;
  logic                   res_valid_q;
  logic [DATA_W-1:0]      res_data_q;
  logic [DEPTH_LOG2:0]    res_len_q;
  logic [1:0]             res_err_q;
  logic [WD_W-1:0]        wd_q;
  // Set when the RAM read register holds data from a legal kernel read this job.
  logic                   a_qv_q;
  logic                   b_qv_q;

  logic                   in_fire;
  logic [DEPTH_LOG2:0]    n_next;
  logic                   a_ok;
  logic                   b_ok;

  logic                   ram_a_ce, ram_a_we, ram_b_ce, ram_b_we;
  logic [DEPTH_LOG2-1:0]  ram_a_addr, ram_b_addr;
  logic [DATA_W-1:0]      ram_a_wd, ram_b_wd, ram_a_rd, ram_b_rd;

  assign in_fire = io.in_valid && in_ready_q;
  assign n_next  = {1'b0, cnt_q} + {{DEPTH_LOG2{1'b0}}, 1'b1};
  assign a_ok    = ~|k_a_address0[ADDR_W-1:DEPTH_LOG2];
  assign b_ok    = ~|k_b_address0[ADDR_W-1:DEPTH_LOG2];

  // RAM port owner: the input stream while loading, the kernel while running.
  always_comb begin
    ram_a_ce   = 1'b0;
    ram_a_we   = 1'b0;
    ram_a_addr = cnt_q;
    ram_a_wd   = io.in_a;
    ram_b_ce   = 1'b0;
    ram_b_we   = 1'b0;
    ram_b_addr = cnt_q;
    ram_b_wd   = io.in_b;
    if (state_q == ST_LOAD) begin
      ram_a_ce = in_fire;
      ram_a_we = 1'b1;
      ram_b_ce = in_fire;
      ram_b_we = 1'b1;
    end else if (state_q == ST_RUN) begin
      ram_a_ce   = k_a_ce0 && a_ok;
      ram_a_we   = k_a_we0;
      ram_a_addr = k_a_address0[DEPTH_LOG2-1:0];
      ram_a_wd   = k_a_ad0;
      ram_b_ce   = k_b_ce0 && b_ok;
      ram_b_we   = k_b_we0;
      ram_b_addr = k_b_address0[DEPTH_LOG2-1:0];
      ram_b_wd   = k_b_ad0;
    end
  end

  dotprod_vec_ram #(.DATA_W(DATA_W), .AW(DEPTH_LOG2)) u_ram_a (
    .clk_i  (sys_clk),
    .ce_i   (ram_a_ce),
    .we_i   (ram_a_we),
    .addr_i (ram_a_addr),
    .wd_i   (ram_a_wd),
    .rd_o   (ram_a_rd)
  );

  dotprod_vec_ram #(.DATA_W(DATA_W), .AW(DEPTH_LOG2)) u_ram_b (
    .clk_i  (sys_clk),
    .ce_i   (ram_b_ce),
    .we_i   (ram_b_we),
    .addr_i (ram_b_addr),
    .wd_i   (ram_b_wd),
    .rd_o   (ram_b_rd)
  );

  // Job sequencing FSM with all handshake and kernel-control outputs registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      k_start_q   <= 1'b0;
      k_n_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_len_q   <= '0;
      res_err_q   <= '0;
      wd_q        <= '0;
      a_qv_q      <= 1'b0;
      b_qv_q      <= 1'b0;
    end else begin
      k_start_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (in_fire) begin
            cnt_q <= cnt_q + DEPTH_LOG2'(1);
            // A full RAM ends the vector even without in_last.
            if (io.in_last || (&cnt_q)) begin
              if (!io.in_last) begin
                res_err_q[ERR_OVF] <= 1'b1;
              end
              state_q    <= ST_KICK;
              in_ready_q <= 1'b0;
              k_start_q  <= 1'b1;
              res_len_q  <= n_next;
              k_n_q      <= 32'(n_next);
            end
          end
        end
        ST_KICK: begin
          state_q <= ST_RUN;
          wd_q    <= WD_W'(TIMEOUT - 1);
          a_qv_q  <= 1'b0;
          b_qv_q  <= 1'b0;
        end
        ST_RUN: begin
          if ((k_a_ce0 && !a_ok) || (k_b_ce0 && !b_ok)) begin
            res_err_q[ERR_OVF] <= 1'b1;
          end
          if (k_done) begin
            res_data_q  <= k_return_val;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESULT;
            a_qv_q      <= 1'b0;
            b_qv_q      <= 1'b0;
          end else if (wd_q == '0) begin
            res_data_q             <= '0;
            res_err_q[ERR_TIMEOUT] <= 1'b1;
            res_valid_q            <= 1'b1;
            state_q                <= ST_RESULT;
            a_qv_q                 <= 1'b0;
            b_qv_q                 <= 1'b0;
          end else begin
            wd_q <= wd_q - WD_W'(1);
            if (k_a_ce0 && !k_a_we0) begin
              a_qv_q <= a_ok;
            end
            if (k_b_ce0 && !k_b_we0) begin
              b_qv_q <= b_ok;
            end
          end
        end
        ST_RESULT: begin
          if (io.res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
            res_err_q   <= '0;
            k_n_q       <= '0;
            state_q     <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_len   = res_len_q;
  assign io.res_err   = res_err_q;
  assign k_start      = k_start_q;
  assign k_n          = k_n_q;
  assign k_a_q0       = a_qv_q ? ram_a_rd : '0;
  assign k_b_q0       = b_qv_q ? ram_b_rd : '0;

endmodule
